cond_check_arbiter: RTL and testbench

COND_CHECK_ARBITER -- requirements
Module: cond_check_arbiter

---
 rtl/cond_arb_pkg.sv | 16 +
 rtl/cond_check_arbiter_rr_picker.sv | 34 +++
 rtl/cond_check_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cond_check_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_arb_pkg.sv
// Shared types and default sizing for the condition-check arbiter.
// Holds the FSM state enum and default N_REQ / MAX_BURST values.
package cond_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 4;

    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/cond_check_arbiter_rr_picker.sv
// Combinational round-robin winner selection.
// Ports: i_req (requests), i_ptr (start index) ->
//        o_onehot (winner), o_idx (winner index), o_any (any request).
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_onehot,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_any
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] w_j;

    // Scan from i_ptr upward, wrapping; the first requester found wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_j = IW'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end
        end
    end

endmodule

// File: rtl/cond_check_arbiter.sv
// Round-robin arbiter sampling one requester's condition bit per grant.
// Ports: clk, rst_n (async active-low), req/din_rvs/en inputs;
//        gnt, flag, flag_vld, flag_id, busy registered outputs.
// Optional: define COND_ARB_STICKY_EN for burst (sticky) grants.
module cond_check_arbiter
    import cond_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         din_rvs,
    input  logic                     en,
    output logic [N_REQ-1:0]         gnt,
    output logic                     flag,
    output logic                     flag_vld,
    output logic [$clog2(N_REQ)-1:0] flag_id,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ out of range 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST out of range 1..15");
    end

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]    r_id, w_id_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic             r_flag, w_flag_nxt;
    logic             r_flag_vld, w_flag_vld_nxt;
    logic [IW-1:0]    r_flag_id, w_flag_id_nxt;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [IW-1:0]    w_ptr_inc;
    logic             w_sample;

`ifdef COND_ARB_STICKY_EN
    logic [BURST_W-1:0] r_burst, w_burst_nxt;
    logic [N_REQ-1:0]   w_id_onehot;
    logic               w_stay;
`endif

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Pointer moves just past the requester that was served.
    assign w_ptr_inc = (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
    assign w_sample  = din_rvs[r_id] & en;

`ifdef COND_ARB_STICKY_EN
    assign w_id_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_id;
    assign w_stay      = req[r_id] &&
                         (r_burst < BURST_W'(MAX_BURST));
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_id_nxt       = r_id;
        w_ptr_nxt      = r_ptr;
        w_flag_nxt     = r_flag;
        w_flag_vld_nxt = r_flag_vld;
        w_flag_id_nxt  = r_flag_id;
`ifdef COND_ARB_STICKY_EN
        w_burst_nxt    = r_burst;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_id_nxt    = w_pick_idx;
                    w_state_nxt = ST_GRANT;
`ifdef COND_ARB_STICKY_EN
                    w_burst_nxt = BURST_W'(1);
`endif
                end
            end
            ST_GRANT: begin
                // Sampled even if req dropped during the grant.
                w_flag_nxt     = w_sample;
                w_flag_vld_nxt = 1'b1;
                w_flag_id_nxt  = r_id;
                w_gnt_nxt      = '0;
                w_state_nxt    = ST_RESP;
            end
            ST_RESP: begin
                w_flag_vld_nxt = 1'b0;
`ifdef COND_ARB_STICKY_EN
                if (w_stay) begin
                    // Same requester again, pointer held.
                    w_gnt_nxt   = w_id_onehot;
                    w_burst_nxt = r_burst + 1'b1;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                end
`else
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = ST_IDLE;
`endif
            end
            default: begin
                w_gnt_nxt      = '0;
                w_flag_vld_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_id       <= '0;
            r_ptr      <= '0;
            r_flag     <= 1'b0;
            r_flag_vld <= 1'b0;
            r_flag_id  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_id       <= w_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_flag     <= w_flag_nxt;
            r_flag_vld <= w_flag_vld_nxt;
            r_flag_id  <= w_flag_id_nxt;
        end
    end

`ifdef COND_ARB_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= '0;
        end else begin
            r_burst <= w_burst_nxt;
        end
    end
`endif

    assign gnt      = r_gnt;
    assign flag     = r_flag;
    assign flag_vld = r_flag_vld;
    assign flag_id  = r_flag_id;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cond_check_arbiter.sv
// Scoreboard bench for cond_check_arbiter with directed vectors.
// Expected pulses are queued by stimulus and popped by a monitor.
module tb_cond_check_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic       en = 1'b0;
    logic [3:0] gnt;
    logic       flag;
    logic       flag_vld;
    logic [1:0] flag_id;
    logic       busy;

    cond_check_arbiter #(
        .N_REQ     (4),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din_rvs  (din),
        .en       (en),
        .gnt      (gnt),
        .flag     (flag),
        .flag_vld (flag_vld),
        .flag_id  (flag_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_pulse = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic       flag;
        logic [1:0] id;
        int         gap;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic f, input logic [1:0] id,
                                 input int gap);
        exp_t e;
        e.flag = f;
        e.id   = id;
        e.gap  = gap;
        sb.push_back(e);
    endfunction

    // Monitor: pop one expectation per flag_vld pulse.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && flag_vld) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got id %0d expected none",
                             flag_id);
                end else begin
                    e = sb.pop_front();
                    chk("flag", 32'(flag), 32'(e.flag));
                    chk("flag_id", 32'(flag_id), 32'(e.id));
                    if (e.gap > 0)
                        chk("pulse_gap", 32'(cyc - last_pulse), 32'(e.gap));
                end
                last_pulse = cyc;
            end
        end
    end

    // Apply inputs, hold until npulse samples seen, then drop req.
    task automatic run(input logic [3:0] r, input logic [3:0] d,
                       input logic e, input int npulse);
        int seen;
        int budget;
        seen = 0;
        budget = 0;
        @(negedge clk);
        req = r;
        din = d;
        en  = e;
        while (seen < npulse && budget < 200) begin
            @(negedge clk);
            budget++;
            if (flag_vld) seen++;
        end
        if (seen < npulse) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d pulses expected %0d",
                     seen, npulse);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_vld", 32'(flag_vld), 32'h0);
        chk("rst_id", 32'(flag_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request; req dropped while in GRANT
        req = 4'b0100;
        din = 4'b0100;
        en  = 1'b1;
        push(1'b1, 2'd2, 0);
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_busy", 32'(busy), 32'h1);
        req = '0;
        @(negedge clk);
        chk("t1_gnt_off", 32'(gnt), 32'h0);
        chk("t1_vld", 32'(flag_vld), 32'h1);
        repeat (4) @(negedge clk);

        // Reset asserted mid-grant
        req = 4'b0010;
        din = 4'b0000;
        @(negedge clk);
        chk("rm_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("rm_gnt0", 32'(gnt), 32'h0);
        chk("rm_flag0", 32'(flag), 32'h0);
        chk("rm_vld0", 32'(flag_vld), 32'h0);
        chk("rm_id0", 32'(flag_id), 32'h0);
        chk("rm_busy0", 32'(busy), 32'h0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        din = 4'b1000;
        push(1'b1, 2'd3, 0);
        @(negedge clk);
        chk("rm_gnt3", 32'(gnt), 32'h8);
        req = '0;
        @(negedge clk);
        chk("rm_vld3", 32'(flag_vld), 32'h1);
        chk("rm_id3", 32'(flag_id), 32'h3);
        repeat (4) @(negedge clk);

`ifdef COND_ARB_STICKY_EN
        // Sticky burst of 4 on requester 0, then 1
        push(1'b1, 2'd0, 0);
        push(1'b1, 2'd0, 2);
        push(1'b1, 2'd0, 2);
        push(1'b1, 2'd0, 2);
        push(1'b0, 2'd1, 3);
        run(4'b0011, 4'b0001, 1'b1, 5);
`else
        // All requesting from ptr 0
        push(1'b0, 2'd0, 0);
        push(1'b1, 2'd1, 3);
        push(1'b0, 2'd2, 3);
        push(1'b1, 2'd3, 3);
        push(1'b0, 2'd0, 3);
        run(4'b1111, 4'b1010, 1'b1, 5);
`endif

        // Move pointer to 3
        push(1'b0, 2'd2, 0);
        run(4'b0100, 4'b0000, 1'b1, 1);

        // Wrap: 3 before 0
`ifdef COND_ARB_STICKY_EN
        push(1'b1, 2'd3, 0);
        push(1'b1, 2'd3, 2);
        push(1'b1, 2'd3, 2);
        push(1'b1, 2'd3, 2);
        push(1'b0, 2'd0, 3);
        run(4'b1001, 4'b1000, 1'b1, 5);
`else
        push(1'b1, 2'd3, 0);
        push(1'b0, 2'd0, 3);
        run(4'b1001, 4'b1000, 1'b1, 2);
`endif

        // Enable gating
        push(1'b0, 2'd0, 0);
        run(4'b0001, 4'b1111, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
